// File: rtl/d7s_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d7s_pkg
// Purpose  : Shared types and constants for the 7-segment scan controller.
//            Segment patterns are {g,f,e,d,c,b,a}, active high.
// Contents : state_t       scan FSM state
//            SEG_0..SEG_F  hex glyph patterns
// Revision : 1.0  initial release
// ============================================================================
package d7s_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

endpackage : d7s_pkg
`default_nettype wire

// File: rtl/d7s_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : d7s_scan_ctrl_if
// Purpose  : Valid/ready load channel carrying one display word.
// Signals  : load_valid  requester offers load_data
//            load_ready  controller can take a word this cycle
//            load_data   4*NUM_DIGITS hex codes, digit 0 in [3:0]
// Modports : master (requester), slave (scan controller)
// Revision : 1.0  initial release
// ============================================================================
interface d7s_scan_ctrl_if #(
    parameter int NUM_DIGITS = 3
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface : d7s_scan_ctrl_if
`default_nettype wire

// File: rtl/d7s_scan_ctrl_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational hex digit to 7-segment pattern decoder.
// Ports    : i_hex  4-bit hex code
//            o_seg  {g,f,e,d,c,b,a}, active high
// Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import d7s_pkg::*;
(
    input  wire logic [3:0] i_hex,
    output logic      [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        case (i_hex)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_0;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/d7s_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : d7s_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a common-segment 7-segment
//            display. Each digit visit is BLANK_CYC all-off clocks followed by
//            SCAN_DIV lit clocks. New words arrive over a valid/ready channel
//            into a one-deep pending buffer and are committed to the shown
//            word only at frame wrap or while off, so a frame never tears.
// Ports    : clk        system clock, rising edge
//            rst_n      asynchronous reset, active low
//            enable     1 = scanning, 0 = display off
//            load_if    slave side of the load channel
//            seg        {g,f,e,d,c,b,a}, active high, registered
//            digit_sel  one-hot digit enable, registered
//            frame_tick one-cycle pulse when the scan wraps to digit 0
// Revision : 1.0  initial release
// ============================================================================
module d7s_scan_ctrl
    import d7s_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 1024,
    parameter int BLANK_CYC  = 16,
    parameter int DIV_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             enable,
    d7s_scan_ctrl_if.slave        load_if,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_tick
);

    localparam int                c_IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0]  c_BLANK_LAST = DIV_W'(BLANK_CYC - 1);
    localparam logic [DIV_W-1:0]  c_SHOW_LAST  = DIV_W'(SCAN_DIV - 1);

    state_t                          r_state;
    logic [DIV_W-1:0]                r_presc;
    logic [c_IDX_W-1:0]              r_idx;
    logic [NUM_DIGITS-1:0][3:0]      r_active;
    logic [NUM_DIGITS-1:0][3:0]      r_pending;
    logic                            r_pfull;
    logic [6:0]                      r_seg;
    logic [NUM_DIGITS-1:0]           r_digit_sel;
    logic                            r_frame_tick;

    state_t                          w_state_nxt;
    logic [DIV_W-1:0]                w_presc_nxt;
    logic [c_IDX_W-1:0]              w_idx_nxt;
    logic                            w_wrap;
    logic [6:0]                      w_seg_nxt;
    logic [NUM_DIGITS-1:0]           w_sel_nxt;
    logic [3:0]                      w_digit;
    logic [6:0]                      w_digit_seg;
    logic                            w_accept;
    logic                            w_commit;

    assign w_digit = r_active[r_idx];

    seg7_decode u_seg7_decode (
        .i_hex (w_digit),
        .o_seg (w_digit_seg)
    );

    // Next state, prescaler and digit index. Output patterns are derived
    // from the next state so they change on the same edge as the state.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        w_seg_nxt   = '0;
        w_sel_nxt   = '0;

        if (!enable) begin
            w_state_nxt = OFF;
            w_presc_nxt = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                OFF: begin
                    w_state_nxt = BLANK;
                    w_presc_nxt = '0;
                    w_idx_nxt   = '0;
                end
                BLANK: begin
                    if (r_presc == c_BLANK_LAST) begin
                        w_state_nxt = SHOW;
                        w_presc_nxt = '0;
                    end else begin
                        w_presc_nxt = r_presc + DIV_W'(1);
                    end
                end
                SHOW: begin
                    if (r_presc == c_SHOW_LAST) begin
                        w_state_nxt = BLANK;
                        w_presc_nxt = '0;
                        if (r_idx == c_IDX_LAST) begin
                            w_idx_nxt = '0;
                            w_wrap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + c_IDX_W'(1);
                        end
                    end else begin
                        w_presc_nxt = r_presc + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = OFF;
                    w_presc_nxt = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end

        // SHOW is only ever entered or held with the index unchanged, and the
        // active word never changes across those edges, so the current
        // index and word give the pattern for the next cycle.
        if (w_state_nxt == SHOW) begin
            w_sel_nxt = NUM_DIGITS'(1) << r_idx;
            w_seg_nxt = w_digit_seg;
        end
    end

    // An accept can only happen with the buffer empty, and a commit only with
    // it full, so the two never coincide and there is no bypass path.
    assign w_accept = load_if.load_valid && !r_pfull;
    assign w_commit = r_pfull && (w_wrap || (r_state == OFF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= OFF;
            r_presc      <= '0;
            r_idx        <= '0;
            r_seg        <= '0;
            r_digit_sel  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_idx        <= w_idx_nxt;
            r_seg        <= w_seg_nxt;
            r_digit_sel  <= w_sel_nxt;
            r_frame_tick <= w_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= '0;
            r_pending <= '0;
            r_pfull   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending <= load_if.load_data;
                r_pfull   <= 1'b1;
            end else if (w_commit) begin
                r_active  <= r_pending;
                r_pfull   <= 1'b0;
            end
        end
    end

    assign load_if.load_ready = !r_pfull;
    assign seg                = r_seg;
    assign digit_sel          = r_digit_sel;
    assign frame_tick         = r_frame_tick;

endmodule : d7s_scan_ctrl
`default_nettype wire

// File: tb/tb_d7s_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_d7s_scan_ctrl
// Purpose  : Self-checking bench for d7s_scan_ctrl (3 digits, SCAN_DIV=4,
//            BLANK_CYC=2). A frame-position model predicts outputs each
//            cycle; directed steps add hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_d7s_scan_ctrl;

    localparam int ND    = 3;
    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int PER   = SD + BC;
    localparam int FRAME = ND * PER;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] seg;
    logic [2:0] digit_sel;
    logic       frame_tick;

    d7s_scan_ctrl_if #(.NUM_DIGITS(ND)) load_if ();

    d7s_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC),
        .DIV_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_if    (load_if),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] c_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts clocks since the scan started; position within the
    // frame decides which digit is lit or whether it is dead time.
    bit         m_run;
    int         m_t;
    logic [11:0] m_active;
    logic [11:0] m_pending;
    bit         m_pfull;
    bit         m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run     <= 1'b0;
            m_t       <= 0;
            m_active  <= '0;
            m_pending <= '0;
            m_pfull   <= 1'b0;
            m_tick    <= 1'b0;
        end else begin
            m_tick <= m_run && enable && (((m_t + 1) % FRAME) == 0);
            if (!m_run) begin
                m_run <= enable;
                m_t   <= 0;
            end else if (!enable) begin
                m_run <= 1'b0;
            end else begin
                m_t <= m_t + 1;
            end
            if (load_if.load_valid && !m_pfull) begin
                m_pending <= load_if.load_data;
                m_pfull   <= 1'b1;
            end else if (m_pfull && (!m_run || (enable && (((m_t + 1) % FRAME) == 0)))) begin
                m_active <= m_pending;
                m_pfull  <= 1'b0;
            end
        end
    end

    function automatic logic [9:0] exp_out();
        int pos;
        int d;
        logic [2:0] sel;
        logic [3:0] hx;
        if (!m_run) return '0;
        pos = m_t % FRAME;
        d   = pos / PER;
        if ((pos % PER) < BC) return '0;
        sel    = '0;
        sel[d] = 1'b1;
        hx     = m_active[4*d +: 4];
        return {sel, c_tab[hx]};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            logic [9:0] e;
            e = exp_out();
            check("model_seg", {25'd0, seg}, {25'd0, e[6:0]});
            check("model_sel", {29'd0, digit_sel}, {29'd0, e[9:7]});
            check("model_tick", {31'd0, frame_tick}, {31'd0, m_tick});
            check("model_ready", {31'd0, load_if.load_ready}, {31'd0, !m_pfull});
        end
    end

    task automatic skip(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic load(input logic [11:0] d);
        int cnt;
        cnt = 0;
        load_if.load_valid = 1'b1;
        load_if.load_data  = d;
        while (!load_if.load_ready && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 50) check("load_timeout", 32'd1, 32'd0);
        @(negedge clk);
        load_if.load_valid = 1'b0;
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        #300000;
        check("watchdog", 32'd1, 32'd0);
        summary();
        $finish;
    end

    initial begin
        int cnt;
        rst_n              = 1'b0;
        enable             = 1'b0;
        load_if.load_valid = 1'b0;
        load_if.load_data  = '0;

        // Reset values
        skip(2);
        check("rst_seg", {25'd0, seg}, 32'h0);
        check("rst_sel", {29'd0, digit_sel}, 32'h0);
        check("rst_ready", {31'd0, load_if.load_ready}, 32'h1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_tick", {31'd0, frame_tick}, 32'h0);

        // Scan order with 321
        load(12'h321);
        enable = 1'b1;
        skip(1);
        check("first_tick", {31'd0, frame_tick}, 32'h0);
        check("first_blank", {29'd0, digit_sel}, 32'h0);
        skip(2);
        check("d0_sel", {29'd0, digit_sel}, 32'b001);
        check("d0_seg", {25'd0, seg}, 32'h06);
        skip(6);
        check("d1_sel", {29'd0, digit_sel}, 32'b010);
        check("d1_seg", {25'd0, seg}, 32'h5B);
        skip(6);
        check("d2_sel", {29'd0, digit_sel}, 32'b100);
        check("d2_seg", {25'd0, seg}, 32'h4F);
        skip(4);
        check("wrap_tick", {31'd0, frame_tick}, 32'h1);
        check("wrap_sel", {29'd0, digit_sel}, 32'h0);

        // No tearing: load ABC during digit 1
        skip(8);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 12'hABC;
        skip(1);
        load_if.load_valid = 1'b0;
        check("held_ready", {31'd0, load_if.load_ready}, 32'h0);
        check("tear_d1", {25'd0, seg}, 32'h5B);
        skip(5);
        check("tear_d2", {25'd0, seg}, 32'h4F);
        skip(4);
        check("commit_ready", {31'd0, load_if.load_ready}, 32'h1);
        skip(2);
        check("abc_d0", {25'd0, seg}, 32'h39);
        skip(6);
        check("abc_d1", {25'd0, seg}, 32'h7C);
        skip(6);
        check("abc_d2", {25'd0, seg}, 32'h77);
        check("abc_d2_sel", {29'd0, digit_sel}, 32'b100);

        // Backpressure: two words back to back
        skip(4);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 12'h456;
        skip(1);
        load_if.load_data  = 12'h789;
        cnt = 0;
        while (!load_if.load_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("bp_wait", cnt, 32'd17);
        skip(1);
        load_if.load_valid = 1'b0;
        skip(1);
        check("bp_d0", {25'd0, seg}, 32'h7D);
        skip(25);
        check("bp2_d1", {25'd0, seg}, 32'h7F);
        check("bp2_d1_sel", {29'd0, digit_sel}, 32'b010);

        // Abort mid-digit
        enable = 1'b0;
        skip(1);
        check("abort_seg", {25'd0, seg}, 32'h0);
        check("abort_sel", {29'd0, digit_sel}, 32'h0);
        skip(2);
        enable = 1'b1;
        skip(1);
        check("restart_tick", {31'd0, frame_tick}, 32'h0);
        skip(2);
        check("restart_sel", {29'd0, digit_sel}, 32'b001);
        check("restart_seg", {25'd0, seg}, 32'h6F);

        // Decode sweep on digit 0
        for (int h = 0; h < 16; h++) begin
            @(negedge clk);
            enable = 1'b0;
            skip(1);
            load({8'h00, 4'(h)});
            enable = 1'b1;
            skip(3);
            check($sformatf("sweep_%0h", h), {25'd0, seg}, {25'd0, c_tab[h]});
            check("sweep_sel", {29'd0, digit_sel}, 32'b001);
        end

        // Reset mid-operation with a word pending
        load_if.load_valid = 1'b1;
        load_if.load_data  = 12'h555;
        skip(1);
        load_if.load_valid = 1'b0;
        check("pend_ready", {31'd0, load_if.load_ready}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", {25'd0, seg}, 32'h0);
        check("arst_sel", {29'd0, digit_sel}, 32'h0);
        check("arst_ready", {31'd0, load_if.load_ready}, 32'h1);
        check("arst_tick", {31'd0, frame_tick}, 32'h0);
        enable = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        skip(1);
        enable = 1'b1;
        skip(3);
        check("post_rst_sel", {29'd0, digit_sel}, 32'b001);
        check("post_rst_seg", {25'd0, seg}, 32'h3F);
        skip(20);

        summary();
        $finish;
    end

endmodule : tb_d7s_scan_ctrl
`default_nettype wire
